treeval_loader: RTL

- Sequencer that owns the sideband load/config interface of the treeval evaluator.
- Accepts a valid/ready stream of node records and serialises each record into one-hot field strobes with a shared address/data bus.
- Programs the node count, kicks the evaluator with a reset pulse, then waits a fixed number of completion pulses.
- Returns the root expectation and action through a result handshake; sits between the host/DMA side and treeval.

---
 rtl/treeval_pkg.sv | 38 +++
 rtl/treeval_field_serializer.sv | 81 ++++++++
 rtl/treeval_loader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/treeval_pkg.sv
// Shared widths, node record layout and loader state encoding for the treeval evaluator.
package treeval_pkg;

    localparam int unsigned W_ADDR         = 10;
    localparam int unsigned W_ACTION       = 3;
    localparam int unsigned W_REWARD       = 12;
    localparam int unsigned W_WEIGHT       = 7;
    localparam int unsigned MAX_DATA_WIDTH = 12;
    localparam int unsigned MAX_NUM_NODES  = 1024;

    // Parent value the evaluator expects for the root node.
    localparam logic [W_ADDR-1:0] ROOT_PARENT = '1;

    typedef struct packed {
        logic [W_ADDR-1:0]   addr;
        logic [W_ADDR-1:0]   parent;
        logic [W_ACTION-1:0] action;
        logic [W_REWARD-1:0] reward;
        logic [W_WEIGHT-1:0] weight;
    } node_rec_t;

    typedef enum logic [2:0] {
        LdIdle,
        LdLoad,
        LdConf,
        LdKick,
        LdRun,
        LdResult
    } loader_state_e;

    typedef enum logic [1:0] {
        FieldPar,
        FieldAct,
        FieldRew,
        FieldWgt
    } field_phase_e;

endpackage

// File: rtl/treeval_field_serializer.sv
// Holds one node record and emits its PAR/ACT/REW/WGT field strobes on four consecutive cycles.
module treeval_field_serializer
    import treeval_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rec_valid,
    output logic                      rec_ready,
    input  node_rec_t                 rec,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_par,
    output logic                      mem_act,
    output logic                      mem_rew,
    output logic                      mem_weight,
    output logic [W_ADDR-1:0]         mem_addr,
    output logic [MAX_DATA_WIDTH-1:0] mem_data
);

    node_rec_t    rec_q;
    logic         held_q;
    field_phase_e phase_q;
    logic         last_phase;
    logic         accept;

    assign last_phase = held_q && (phase_q == FieldWgt);
    // A new record may be taken while the last field of the current one is on the bus.
    assign rec_ready  = !held_q || last_phase;
    assign accept     = rec_valid && rec_ready;
    assign busy       = held_q;
    assign done       = last_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q  <= 1'b0;
            phase_q <= FieldPar;
            rec_q   <= '0;
        end else if (accept) begin
            held_q  <= 1'b1;
            phase_q <= FieldPar;
            rec_q   <= rec;
        end else if (held_q) begin
            phase_q <= field_phase_e'(phase_q + 2'd1);
            if (last_phase) begin
                held_q <= 1'b0;
            end
        end
    end

    always_comb begin
        mem_par    = 1'b0;
        mem_act    = 1'b0;
        mem_rew    = 1'b0;
        mem_weight = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        if (held_q) begin
            mem_addr = rec_q.addr;
            unique case (phase_q)
                FieldPar: begin
                    mem_par  = 1'b1;
                    mem_data = (rec_q.addr == '0) ? MAX_DATA_WIDTH'(ROOT_PARENT)
                                                  : MAX_DATA_WIDTH'(rec_q.parent);
                end
                FieldAct: begin
                    mem_act  = 1'b1;
                    mem_data = MAX_DATA_WIDTH'(rec_q.action);
                end
                FieldRew: begin
                    mem_rew  = 1'b1;
                    mem_data = MAX_DATA_WIDTH'(rec_q.reward);
                end
                FieldWgt: begin
                    mem_weight = 1'b1;
                    mem_data   = MAX_DATA_WIDTH'(rec_q.weight);
                end
            endcase
        end
    end

endmodule

// File: rtl/treeval_loader.sv
// Load/config sequencer for the treeval evaluator: streams node records, programs the node count,
// kicks the evaluator and returns the root result. Optional RUN watchdog: TREEVAL_LOADER_TIMEOUT_EN.
module treeval_loader #(
`ifdef TREEVAL_LOADER_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 65535,
`endif
    parameter int unsigned MAX_NODES      = treeval_pkg::MAX_NUM_NODES,
    parameter int unsigned W_ADDR         = treeval_pkg::W_ADDR,
    parameter int unsigned SETTLE_PASSES  = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [W_ADDR-1:0]                      in_addr,
    input  logic [W_ADDR-1:0]                      in_parent,
    input  logic [treeval_pkg::W_ACTION-1:0]       in_action,
    input  logic [treeval_pkg::W_REWARD-1:0]       in_reward,
    input  logic [treeval_pkg::W_WEIGHT-1:0]       in_weight,
    input  logic                                   in_last,
    output logic                                   tv_rst,
    output logic                                   tv_mem_par,
    output logic                                   tv_mem_act,
    output logic                                   tv_mem_rew,
    output logic                                   tv_mem_weight,
    output logic [W_ADDR-1:0]                      tv_mem_addr,
    output logic [treeval_pkg::MAX_DATA_WIDTH-1:0] tv_mem_data,
    output logic                                   tv_conf_nodes,
    output logic [W_ADDR-1:0]                      tv_conf_data,
    input  logic                                   tv_exp_change,
    input  logic [treeval_pkg::W_REWARD-1:0]       tv_exp,
    input  logic [treeval_pkg::W_ACTION-1:0]       tv_act,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [treeval_pkg::W_REWARD-1:0]       res_exp,
    output logic [treeval_pkg::W_ACTION-1:0]       res_act,
    output logic                                   busy,
    output logic                                   err
);
    import treeval_pkg::*;

    localparam logic [2:0] ST_IDLE   = LdIdle;
    localparam logic [2:0] ST_LOAD   = LdLoad;
    localparam logic [2:0] ST_CONF   = LdConf;
    localparam logic [2:0] ST_KICK   = LdKick;
    localparam logic [2:0] ST_RUN    = LdRun;
    localparam logic [2:0] ST_RESULT = LdResult;

    localparam int unsigned      W_CNT   = $clog2(MAX_NODES + 1);
    localparam logic [W_CNT-1:0] MAX_CNT = W_CNT'(MAX_NODES);
    localparam logic [3:0]       SETTLE  = 4'(SETTLE_PASSES);

    logic [2:0]          state_q, state_d;
    logic [W_CNT-1:0]    count_q, count_d;
    logic                last_q, last_d;
    logic                err_q, err_d;
    logic [3:0]          pass_q, pass_d;
    logic [W_REWARD-1:0] res_exp_q, res_exp_d;
    logic [W_ACTION-1:0] res_act_q, res_act_d;

    logic      ser_ready, ser_busy, ser_done, ser_valid;
    logic      accept, room, count_ok;
    node_rec_t in_rec;

    assign in_ready  = (state_q == ST_LOAD) && !last_q && ser_ready;
    assign accept    = in_valid && in_ready;
    assign room      = count_q < MAX_CNT;
    // Records beyond the buffer depth are acknowledged but never written.
    assign ser_valid = accept && room;
    assign count_ok  = (count_q >= W_CNT'(2)) && (count_q <= MAX_CNT);

    always_comb begin
        in_rec        = '0;
        in_rec.addr   = in_addr;
        in_rec.parent = in_parent;
        in_rec.action = in_action;
        in_rec.reward = in_reward;
        in_rec.weight = in_weight;
    end

    treeval_field_serializer u_ser (
        .clk        (clk),
        .rst        (rst),
        .rec_valid  (ser_valid),
        .rec_ready  (ser_ready),
        .rec        (in_rec),
        .busy       (ser_busy),
        .done       (ser_done),
        .mem_par    (tv_mem_par),
        .mem_act    (tv_mem_act),
        .mem_rew    (tv_mem_rew),
        .mem_weight (tv_mem_weight),
        .mem_addr   (tv_mem_addr),
        .mem_data   (tv_mem_data)
    );

`ifdef TREEVAL_LOADER_TIMEOUT_EN
    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wdog_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= (state_q == ST_RUN) ? wdog_q + 16'd1 : '0;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        last_d    = last_q;
        err_d     = err_q;
        pass_d    = pass_q;
        res_exp_d = res_exp_q;
        res_act_d = res_act_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    last_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    last_d = in_last;
                    if (room) begin
                        count_d = count_q + W_CNT'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (last_q && (ser_done || !ser_busy)) begin
                    state_d = err_q ? ST_IDLE : ST_CONF;
                end
            end
            ST_CONF: begin
                if (count_ok) begin
                    state_d = ST_KICK;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_KICK: begin
                pass_d  = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (tv_exp_change) begin
                    pass_d = pass_q + 4'd1;
                    if (pass_q + 4'd1 == SETTLE) begin
                        res_exp_d = tv_exp;
                        res_act_d = tv_act;
                        state_d   = ST_RESULT;
                    end
                end
`ifdef TREEVAL_LOADER_TIMEOUT_EN
                if (state_d == ST_RUN && wdog_q == WDOG_LIMIT) begin
                    err_d     = 1'b1;
                    res_exp_d = 12'h800;
                    res_act_d = '0;
                    state_d   = ST_RESULT;
                end
`endif
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            pass_q    <= '0;
            res_exp_q <= '0;
            res_act_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            last_q    <= last_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            res_exp_q <= res_exp_d;
            res_act_q <= res_act_d;
        end
    end

    assign tv_rst        = rst || (state_q == ST_KICK);
    assign tv_conf_nodes = (state_q == ST_CONF) && count_ok;
    assign tv_conf_data  = count_q[W_ADDR-1:0];
    assign res_valid     = (state_q == ST_RESULT);
    assign res_exp       = res_exp_q;
    assign res_act       = res_act_q;
    assign busy          = (state_q != ST_IDLE);
    assign err           = err_q;

endmodule
